// File: rtl/seq_sched_pkg.sv
// ==== seq_sched_pkg : shared types for the burst scheduler | rev 1.0 ====
`default_nettype none

package seq_sched_pkg;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;
endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ==== rr_arbiter : combinational round-robin pick, searching upward from rr_ptr | rev 1.0 ====
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               any_valid
);

  logic [IDX_W-1:0] sel;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    any_valid  = 1'b0;
    sel        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!any_valid && req[sel]) begin
        any_valid     = 1'b1;
        winner[sel]   = 1'b1;
        winner_idx    = sel;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_burst_scheduler.sv
// ==== seq_burst_scheduler : round-robin sharing of one sequence generator among requesters | rev 1.0 ====
`default_nettype none

module seq_burst_scheduler
  import seq_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     gen_enable,
  input  logic [DATA_W-1:0]        gen_data,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [IDX_W-1:0]         out_owner
);

  state_t             state, state_nxt;
  logic [LEN_W:0]     cnt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [NUM_REQ-1:0] arb_onehot;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [LEN_W-1:0]   win_len;
  logic [LEN_W:0]     win_cnt;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .winner     (arb_onehot),
    .winner_idx (arb_idx),
    .any_valid  (arb_any)
  );

  // A zero length field encodes the maximum burst of 2^LEN_W bytes.
  assign win_len = req_len[int'(arb_idx)*LEN_W +: LEN_W];
  assign win_cnt = (win_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, win_len};

  always_comb begin
    state_nxt  = state;
    gen_enable = 1'b0;
    done       = '0;
    case (state)
      ST_IDLE:  if (arb_any) state_nxt = ST_BURST;
      ST_BURST: begin
        gen_enable = 1'b1;
        if (cnt == (LEN_W+1)'(1)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        done      = grant;
        state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rr_ptr    <= '0;
      grant     <= '0;
      owner     <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= gen_enable;
      case (state)
        ST_IDLE: if (arb_any) begin
          grant  <= arb_onehot;
          owner  <= arb_idx;
          cnt    <= win_cnt;
          rr_ptr <= (arb_idx == IDX_W'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
        end
        ST_BURST: cnt   <= cnt - 1'b1;
        ST_DRAIN: grant <= '0;
        default: ;
      endcase
    end
  end

  assign out_data  = gen_data;
  assign out_owner = owner;

endmodule

`default_nettype wire

// File: tb/tb_seq_burst_scheduler.sv
// ==== tb_seq_burst_scheduler : directed + random bursts against a transaction-level model | rev 1.0 ====
`default_nettype none

module tb_seq_burst_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_len;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        gen_enable;
  logic [7:0]  gen_data;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_owner;

  logic [7:0]  gen_cnt;
  int          passed = 0;
  int          total  = 0;
  int          m_ptr  = 0;
  int          m_byte = 0;

  seq_burst_scheduler #(.NUM_REQ(4), .LEN_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_len    (req_len),
    .grant      (grant),
    .done       (done),
    .gen_enable (gen_enable),
    .gen_data   (gen_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_owner  (out_owner)
  );

  always #5 clk = ~clk;

  // Generator: output register loads the running count on each enabled edge.
  always @(posedge clk) begin
    if (gen_enable === 1'b1) begin
      gen_data <= gen_cnt;
      gen_cnt  <= gen_cnt + 8'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_gen_en"}, gen_enable, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_owner"}, out_owner, 0);
  endtask

  task automatic do_reset;
    reset = 1'b0;
    req   = '0;
    tick;
    check_quiet("rst");
    chk("rst_data_pass", out_data, gen_data);
    @(negedge clk);
    reset = 1'b1;
    m_ptr = 0;
    tick;
  endtask

  // One arbitration from an IDLE cycle; optionally rewrites req/len after grant.
  task automatic burst(input logic [3:0] r, input logic [15:0] lens,
                       input bit chg, input logic [3:0] r2, input logic [15:0] lens2);
    int w;
    int n;
    w = -1;
    req     = r;
    req_len = lens;
    for (int k = 0; k < 4; k++) begin
      if (w < 0 && r[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
    end
    if (w < 0) begin
      tick;
      chk("idle_grant", grant, 0);
      chk("idle_gen_en", gen_enable, 0);
      return;
    end
    n = int'(lens[w*4 +: 4]);
    if (n == 0) n = 16;
    m_ptr = (w + 1) % 4;

    tick;
    chk("t1_grant", grant, 32'(1) << w);
    chk("t1_owner", out_owner, w);
    chk("t1_gen_en", gen_enable, 1);
    chk("t1_valid", out_valid, 0);
    chk("t1_done", done, 0);
    if (chg) begin
      req     = r2;
      req_len = lens2;
    end
    for (int k = 2; k <= n; k++) begin
      tick;
      chk("bu_gen_en", gen_enable, 1);
      chk("bu_valid", out_valid, 1);
      chk("bu_data", out_data, m_byte);
      chk("bu_grant", grant, 32'(1) << w);
      chk("bu_done", done, 0);
      m_byte = (m_byte + 1) % 256;
    end
    tick;
    chk("dr_gen_en", gen_enable, 0);
    chk("dr_valid", out_valid, 1);
    chk("dr_data", out_data, m_byte);
    chk("dr_done", done, 32'(1) << w);
    m_byte = (m_byte + 1) % 256;
    tick;
    chk("end_grant", grant, 0);
    chk("end_done", done, 0);
    chk("end_valid", out_valid, 0);
    chk("end_gen_en", gen_enable, 0);
  endtask

  initial begin
    reset    = 1'b0;
    req      = '0;
    req_len  = '0;
    gen_cnt  = 8'h00;
    gen_data = 8'h00;

    do_reset;
    burst(4'b0010, 16'h0030, 1'b0, '0, '0);
    burst(4'b0001, 16'h0000, 1'b0, '0, '0);

    do_reset;
    for (int i = 0; i < 5; i++) burst(4'b1111, 16'h1111, 1'b0, '0, '0);
    req = '0;
    tick;

    burst(4'b0100, 16'h0500, 1'b1, 4'b0000, 16'h0100);

    req     = 4'b0001;
    req_len = 16'h0006;
    tick;
    chk("ab_grant", grant, 4'b0001);
    tick;
    tick;
    chk("ab_gen_en", gen_enable, 1);
    #1 reset = 1'b0;
    #1;
    check_quiet("ab");
    m_byte = (m_byte + 2) % 256;
    m_ptr  = 0;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("ab_hold_done", done, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    burst(4'b1100, 16'h0200, 1'b0, '0, '0);

    burst(4'b0001, 16'h2222, 1'b0, '0, '0);
    burst(4'b0010, 16'h2222, 1'b0, '0, '0);

    for (int i = 0; i < 25; i++) begin
      burst(4'($urandom_range(0, 15)), 16'($urandom), 1'b0, '0, '0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
